// File: rtl/mem_row_reducer_if.sv
// Bundle connecting the row reducer to its request source, memory_block read port and result fifo.
// The master modport is the reducer side; slave is the environment side.
interface mem_row_reducer_if #(
  parameter int unsigned DATAW = 8,
  parameter int unsigned ADDRW = 9,
  parameter int unsigned ACCW  = 32
);
  logic             start;
  logic [ADDRW-1:0] base_addr;
  logic [ADDRW:0]   length;
  logic             busy;
  logic [ADDRW-1:0] raddr;
  logic [DATAW-1:0] rdata;
  logic             fifo_push;
  logic [ACCW-1:0]  fifo_data;
  logic             fifo_full;
  logic             done;

  modport master (
    input  start, base_addr, length, rdata, fifo_full,
    output busy, raddr, fifo_push, fifo_data, done
  );

  modport slave (
    output start, base_addr, length, rdata, fifo_full,
    input  busy, raddr, fifo_push, fifo_data, done
  );
endinterface

// File: rtl/mem_row_reducer.sv
// Issues a run of consecutive reads to a 2-cycle-latency memory, sums the words as signed
// values and pushes the single sum into the result fifo.
module mem_row_reducer #(
  parameter int unsigned DATAW = 8,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned ADDRW = $clog2(DEPTH),
  parameter int unsigned ACCW  = 32
) (
  input logic              clk,
  input logic              rst,
  mem_row_reducer_if.master bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StPush} state_e;

  state_e           state_q, state_d;
  logic [ADDRW-1:0] raddr_q, raddr_d;
  logic [ADDRW:0]   len_q, len_d;
  logic [ADDRW:0]   cnt_q, cnt_d;
  logic [ACCW-1:0]  acc_q, acc_d;
  logic [1:0]       tag_q, tag_d;
  logic             push;
  logic [ACCW-1:0]  rdata_ext;

  assign rdata_ext = ACCW'($signed(bus.rdata));

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    // tag[0]: address on raddr this cycle was a real read; tag[1]: its data arrives now
    tag_d   = {tag_q[0], state_q == StIssue};
    acc_d   = tag_q[1] ? acc_q + rdata_ext : acc_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          len_d = bus.length;
          cnt_d = '0;
          acc_d = '0;
          if (bus.length != '0) begin
            raddr_d = bus.base_addr;
            state_d = StIssue;
          end else begin
            state_d = StPush;
          end
        end
      end
      StIssue: begin
        if (cnt_q == len_q - (ADDRW+1)'(1)) begin
          state_d = StDrain;
        end else begin
          cnt_d   = cnt_q + (ADDRW+1)'(1);
          raddr_d = (raddr_q == ADDRW'(DEPTH - 1)) ? '0 : raddr_q + ADDRW'(1);
        end
      end
      StDrain: begin
        // last word is being accumulated on this edge once tag[0] has emptied
        if (!tag_q[0]) state_d = StPush;
      end
      StPush: begin
        push = !bus.fifo_full;
        if (push) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      raddr_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      tag_q   <= tag_d;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.raddr     = raddr_q;
  assign bus.fifo_push = push;
  assign bus.done      = push;
  assign bus.fifo_data = acc_q;

endmodule

// File: tb/tb_mem_row_reducer.sv
// Directed bench for mem_row_reducer with a 2-cycle-latency memory model.
module tb_mem_row_reducer;

  localparam int unsigned DATAW = 8;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned ADDRW = 9;
  localparam int unsigned ACCW  = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_row_reducer_if #(.DATAW(DATAW), .ADDRW(ADDRW), .ACCW(ACCW)) bus_if ();

  mem_row_reducer #(.DATAW(DATAW), .DEPTH(DEPTH), .ACCW(ACCW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  logic [DATAW-1:0] mem [DEPTH];
  logic [DATAW-1:0] rd_p;
  logic [DATAW-1:0] rd_q;

  always_ff @(posedge clk) begin
    rd_p <= mem[bus_if.raddr];
    rd_q <= rd_p;
  end
  assign bus_if.rdata = rd_q;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input int base, input int len, input int exp_cyc,
                        input logic [31:0] exp_data);
    int cyc;
    bus_if.start     = 1'b1;
    bus_if.base_addr = ADDRW'(base);
    bus_if.length    = (ADDRW+1)'(len);
    tick();
    bus_if.start = 1'b0;
    cyc = 1;
    while (!bus_if.fifo_push && cyc < 2000) begin
      tick();
      cyc++;
    end
    chk({tag, "_cycle"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_data"}, 64'(bus_if.fifo_data), 64'(exp_data));
    chk({tag, "_done"}, 64'(bus_if.done), 64'd1);
    tick();
    chk({tag, "_idle"}, 64'(bus_if.busy), 64'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[5] = 8'd1; mem[6] = 8'd2; mem[7] = 8'd3; mem[8] = 8'd4;
    rst = 1'b0;
    bus_if.start     = 1'b0;
    bus_if.base_addr = '0;
    bus_if.length    = '0;
    bus_if.fifo_full = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_busy", 64'(bus_if.busy), 64'd0);
    chk("rst_push", 64'(bus_if.fifo_push), 64'd0);
    chk("rst_done", 64'(bus_if.done), 64'd0);
    chk("rst_raddr", 64'(bus_if.raddr), 64'd0);
    chk("rst_data", 64'(bus_if.fifo_data), 64'd0);
    rst = 1'b1;
    tick();

    // base 5, len 4: cycle-by-cycle timing
    bus_if.start = 1'b1; bus_if.base_addr = 9'd5; bus_if.length = 10'd4;
    tick();
    bus_if.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("t1_raddr_c%0d", c), 64'(bus_if.raddr), (c <= 4) ? 64'(4 + c) : 64'd8);
      chk($sformatf("t1_push_c%0d", c), 64'(bus_if.fifo_push), (c == 7) ? 64'd1 : 64'd0);
      chk($sformatf("t1_busy_c%0d", c), 64'(bus_if.busy), (c <= 7) ? 64'd1 : 64'd0);
      if (c == 7) begin
        chk("t1_data", 64'(bus_if.fifo_data), 64'd10);
        chk("t1_done", 64'(bus_if.done), 64'd1);
      end
      tick();
    end

    // Signed accumulation: -1 + -128 + 1 = -128
    mem[0] = 8'hFF; mem[1] = 8'h80; mem[2] = 8'h01;
    run_op("neg", 0, 3, 6, 32'hFFFF_FF80);

    // Address wrap DEPTH-1 -> 0
    mem[510] = 8'd10; mem[511] = 8'd20; mem[0] = 8'd30; mem[1] = 8'd40;
    run_op("wrap", 510, 4, 7, 32'd100);

    // Backpressure in PUSH for 5 cycles
    bus_if.fifo_full = 1'b1;
    bus_if.start = 1'b1; bus_if.base_addr = 9'd5; bus_if.length = 10'd4;
    tick();
    bus_if.start = 1'b0;
    for (int c = 2; c <= 7; c++) tick();
    for (int c = 7; c <= 11; c++) begin
      chk($sformatf("full_push_c%0d", c), 64'(bus_if.fifo_push), 64'd0);
      chk($sformatf("full_data_c%0d", c), 64'(bus_if.fifo_data), 64'd10);
      chk($sformatf("full_busy_c%0d", c), 64'(bus_if.busy), 64'd1);
      tick();
    end
    bus_if.fifo_full = 1'b0;
    #1;
    chk("full_release_push", 64'(bus_if.fifo_push), 64'd1);
    chk("full_release_data", 64'(bus_if.fifo_data), 64'd10);
    tick();
    chk("full_after_push", 64'(bus_if.fifo_push), 64'd0);
    chk("full_after_busy", 64'(bus_if.busy), 64'd0);

    // Start during ISSUE is ignored
    mem[100] = 8'd50; mem[101] = 8'd60;
    bus_if.start = 1'b1; bus_if.base_addr = 9'd5; bus_if.length = 10'd4;
    tick();
    bus_if.start = 1'b0;
    tick();
    bus_if.start = 1'b1; bus_if.base_addr = 9'd100; bus_if.length = 10'd2;
    tick();
    bus_if.start = 1'b0;
    for (int c = 3; c < 7; c++) tick();
    chk("ign_push", 64'(bus_if.fifo_push), 64'd1);
    chk("ign_data", 64'(bus_if.fifo_data), 64'd10);
    tick();
    chk("ign_busy", 64'(bus_if.busy), 64'd0);
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("ign_nopush_%0d", c), 64'(bus_if.fifo_push), 64'd0);
      tick();
    end

    // Zero length pushes 0 in cycle 1
    run_op("len0", 7, 0, 1, 32'd0);

    // Reset during ISSUE aborts without a push
    bus_if.start = 1'b1; bus_if.base_addr = 9'd5; bus_if.length = 10'd4;
    tick();
    bus_if.start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort_busy", 64'(bus_if.busy), 64'd0);
    chk("abort_push", 64'(bus_if.fifo_push), 64'd0);
    chk("abort_raddr", 64'(bus_if.raddr), 64'd0);
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("abort_nopush_%0d", c), 64'(bus_if.fifo_push), 64'd0);
      tick();
    end
    run_op("after_abort", 5, 4, 7, 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
